// File: rtl/vend_ctrl.sv
// Vending-machine controller: accumulates three coin denominations, vends at PRICE,
// then pays change greedily one coin per cycle. Supports cancel/refund and coin rejection.
module vend_ctrl #(
  parameter int unsigned CW    = 4,
  parameter int unsigned PRICE = 5,
  parameter int unsigned V1    = 1,
  parameter int unsigned V2    = 2,
  parameter int unsigned V3    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d1,
  input  logic          d2,
  input  logic          d3,
  input  logic          cancel,
  output logic          out1,
  output logic [1:0]    out2,
  output logic          chg_valid,
  output logic          coin_reject,
  output logic [CW-1:0] credit,
  output logic          busy
);

  localparam logic [CW-1:0] PriceW = CW'(PRICE);
  localparam logic [CW-1:0] V1W    = CW'(V1);
  localparam logic [CW-1:0] V2W    = CW'(V2);
  localparam logic [CW-1:0] V3W    = CW'(V3);

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          reject_q, reject_d;

  logic          coin_any, coin_one, coin_ok;
  logic [CW-1:0] coin_val, credit_sum;
  logic [CW-1:0] chg_val;
  logic [1:0]    chg_code;

  always_comb begin
    coin_any = d1 | d2 | d3;
    coin_one = $onehot({d1, d2, d3});
    coin_ok  = coin_one & ~cancel;
    if (d3)      coin_val = V3W;
    else if (d2) coin_val = V2W;
    else         coin_val = V1W;
    credit_sum = credit_q + coin_val;
  end

  // Greedy change: largest denomination not exceeding remaining credit.
  always_comb begin
    if (credit_q >= V3W) begin
      chg_val  = V3W;
      chg_code = 2'd3;
    end else if (credit_q >= V2W) begin
      chg_val  = V2W;
      chg_code = 2'd2;
    end else begin
      chg_val  = V1W;
      chg_code = 2'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    unique case (state_q)
      StIdle, StCollect: begin
        reject_d = coin_any & ~coin_ok;
        // Cancel wins over any coin sampled with it; that coin is rejected above.
        if (cancel && state_q == StCollect) begin
          state_d = StChange;
        end else if (coin_ok) begin
          credit_d = credit_sum;
          state_d  = (credit_sum >= PriceW) ? StVend : StCollect;
        end
      end
      StVend: begin
        reject_d = coin_any;
        credit_d = credit_q - PriceW;
        state_d  = (credit_q != PriceW) ? StChange : StIdle;
      end
      StChange: begin
        reject_d = coin_any;
        credit_d = credit_q - chg_val;
        state_d  = (credit_q == chg_val) ? StIdle : StChange;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    out1        = (state_q == StVend);
    chg_valid   = (state_q == StChange);
    out2        = (state_q == StChange) ? chg_code : 2'd0;
    busy        = (state_q == StVend) || (state_q == StChange);
    coin_reject = reject_q;
    credit      = credit_q;
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl with default parameters (PRICE=5, coins 1/2/4).
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d1 = 1'b0, d2 = 1'b0, d3 = 1'b0, cancel = 1'b0;
  logic       out1, chg_valid, coin_reject, busy;
  logic [1:0] out2;
  logic [3:0] credit;

  int checks = 0;
  int errors = 0;

  vend_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .cancel      (cancel),
    .out1        (out1),
    .out2        (out2),
    .chg_valid   (chg_valid),
    .coin_reject (coin_reject),
    .credit      (credit),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {out1, chg_valid, out2, coin_reject, busy, credit}.
  function automatic logic [9:0] obs();
    return {out1, chg_valid, out2, coin_reject, busy, credit};
  endfunction

  function automatic logic [9:0] exp_v(input logic o1, input logic cv, input logic [1:0] o2,
                                       input logic rj, input logic bz, input logic [3:0] cr);
    return {o1, cv, o2, rj, bz, cr};
  endfunction

  // Apply inputs across one rising edge, then return 1 time unit after it.
  task automatic step(input logic a1, input logic a2, input logic a3, input logic c);
    d1 = a1; d2 = a2; d3 = a3; cancel = c;
    @(posedge clk);
    #1;
    d1 = 1'b0; d2 = 1'b0; d3 = 1'b0; cancel = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd0)) begin
      errors++; $display("FAIL reset_hold: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd0));
    end
    @(posedge clk); #1; rst = 1'b1;
    step(0, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd0)) begin
      errors++; $display("FAIL reset_idle: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd0));
    end
  endtask

  task automatic test_exact();
    step(1, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd1)) begin
      errors++; $display("FAIL exact_c1: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd1));
    end
    step(0, 1, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd3)) begin
      errors++; $display("FAIL exact_c3: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd3));
    end
    step(1, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd4)) begin
      errors++; $display("FAIL exact_c4: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd4));
    end
    step(1, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(1, 0, 2'd0, 0, 1, 4'd5)) begin
      errors++; $display("FAIL exact_vend: got %h want %h", obs(), exp_v(1, 0, 2'd0, 0, 1, 4'd5));
    end
    step(0, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd0)) begin
      errors++; $display("FAIL exact_idle: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd0));
    end
  endtask

  task automatic test_overpay();
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    checks++;
    if (obs() !== exp_v(1, 0, 2'd0, 0, 1, 4'd6)) begin
      errors++; $display("FAIL over_vend: got %h want %h", obs(), exp_v(1, 0, 2'd0, 0, 1, 4'd6));
    end
    step(0, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 1, 2'd1, 0, 1, 4'd1)) begin
      errors++; $display("FAIL over_chg: got %h want %h", obs(), exp_v(0, 1, 2'd1, 0, 1, 4'd1));
    end
    step(0, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd0)) begin
      errors++; $display("FAIL over_idle: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd0));
    end
  endtask

  // reject_mid drives d3 during the first change coin.
  task automatic test_greedy(input logic reject_mid);
    step(0, 0, 1, 0);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd4)) begin
      errors++; $display("FAIL greedy_c4: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd4));
    end
    step(0, 0, 1, 0);
    checks++;
    if (obs() !== exp_v(1, 0, 2'd0, 0, 1, 4'd8)) begin
      errors++; $display("FAIL greedy_vend: got %h want %h", obs(), exp_v(1, 0, 2'd0, 0, 1, 4'd8));
    end
    step(0, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 1, 2'd2, 0, 1, 4'd3)) begin
      errors++; $display("FAIL greedy_chg2: got %h want %h", obs(), exp_v(0, 1, 2'd2, 0, 1, 4'd3));
    end
    step(0, 0, reject_mid, 0);
    checks++;
    if (obs() !== exp_v(0, 1, 2'd1, reject_mid, 1, 4'd1)) begin
      errors++;
      $display("FAIL greedy_chg1: got %h want %h", obs(), exp_v(0, 1, 2'd1, reject_mid, 1, 4'd1));
    end
    step(0, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd0)) begin
      errors++; $display("FAIL greedy_idle: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd0));
    end
  endtask

  task automatic test_cancel();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd3)) begin
      errors++; $display("FAIL cancel_c3: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd3));
    end
    step(0, 0, 0, 1);
    checks++;
    if (obs() !== exp_v(0, 1, 2'd2, 0, 1, 4'd3)) begin
      errors++; $display("FAIL cancel_chg2: got %h want %h", obs(), exp_v(0, 1, 2'd2, 0, 1, 4'd3));
    end
    step(0, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 1, 2'd1, 0, 1, 4'd1)) begin
      errors++; $display("FAIL cancel_chg1: got %h want %h", obs(), exp_v(0, 1, 2'd1, 0, 1, 4'd1));
    end
    step(0, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd0)) begin
      errors++; $display("FAIL cancel_idle: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd0));
    end
    // Cancel in IDLE is ignored.
    step(0, 0, 0, 1);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd0)) begin
      errors++; $display("FAIL cancel_ign: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd0));
    end
  endtask

  task automatic test_reject();
    step(1, 1, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 1, 0, 4'd0)) begin
      errors++; $display("FAIL rej_multi: got %h want %h", obs(), exp_v(0, 0, 2'd0, 1, 0, 4'd0));
    end
    step(0, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd0)) begin
      errors++; $display("FAIL rej_clear: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd0));
    end
    test_greedy(1'b1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 1);
    checks++;
    if (obs() !== exp_v(0, 1, 2'd2, 1, 1, 4'd2)) begin
      errors++; $display("FAIL rej_cancel: got %h want %h", obs(), exp_v(0, 1, 2'd2, 1, 1, 4'd2));
    end
    step(0, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd0)) begin
      errors++; $display("FAIL rej_cancel_idle: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd0));
    end
  endtask

  task automatic test_reset_mid_change();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 1, 2'd2, 0, 1, 4'd3)) begin
      errors++; $display("FAIL rst_pre: got %h want %h", obs(), exp_v(0, 1, 2'd2, 0, 1, 4'd3));
    end
    #2; rst = 1'b0;
    #1;
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd0)) begin
      errors++; $display("FAIL rst_async: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd0));
    end
    @(posedge clk); #3; rst = 1'b1;
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd4)) begin
      errors++; $display("FAIL rst_c4: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd4));
    end
    step(1, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(1, 0, 2'd0, 0, 1, 4'd5)) begin
      errors++; $display("FAIL rst_vend: got %h want %h", obs(), exp_v(1, 0, 2'd0, 0, 1, 4'd5));
    end
    step(0, 0, 0, 0);
    checks++;
    if (obs() !== exp_v(0, 0, 2'd0, 0, 0, 4'd0)) begin
      errors++; $display("FAIL rst_idle: got %h want %h", obs(), exp_v(0, 0, 2'd0, 0, 0, 4'd0));
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_overpay();
    test_greedy(1'b0);
    test_cancel();
    test_reject();
    test_reset_mid_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
